// File: rtl/md_scheduler_if.sv
// Pipeline-side bundle for md_scheduler: op issue, hazard feedback and HI/LO read ports.
// The master side (EX stage / hazard logic) drives the op; the slave side is the scheduler.
interface md_scheduler_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        mf_req;
   logic        cancel;
   logic        busy;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, op, a, b, mf_req, cancel,
      input  busy, stall, hi, lo
   );

   modport slave (
      input  start, op, a, b, mf_req, cancel,
      output busy, stall, hi, lo
   );
endinterface

// File: rtl/md_scheduler.sv
// Multiply/divide sequencer owning HI/LO; latency is modelled with a down-counter.
// Optional feature: define MD_CANCEL_EN to let cancel abort an in-flight operation.
module md_scheduler #(
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10
) (
   input logic           clk,
   input logic           reset,
   md_scheduler_if.slave md
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2
   } state_e;

   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6,
      OP_RSV   = 3'd7
   } op_e;

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
   localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

`ifdef MD_CANCEL_EN
   localparam logic CANCEL_ON = 1'b1;
`else
   localparam logic CANCEL_ON = 1'b0;
`endif

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   op_e              op_q,    op_d;
   logic [31:0]      a_q,     a_d;
   logic [31:0]      b_q,     b_d;
   logic [31:0]      hi_q,    hi_d;
   logic [31:0]      lo_q,    lo_d;

   logic        cancel_act;
   logic signed [63:0] a_sx, b_sx;
   logic [63:0] prod_s, prod_u;
   logic [31:0] quo_s, rem_s, quo_u, rem_u;

   assign cancel_act = CANCEL_ON & md.cancel;

   // Results are formed from the latched operands, so forwarding changes on a/b
   // after acceptance cannot disturb an in-flight operation.
   assign a_sx   = {{32{a_q[31]}}, a_q};
   assign b_sx   = {{32{b_q[31]}}, b_q};
   assign prod_s = a_sx * b_sx;
   assign prod_u = {32'd0, a_q} * {32'd0, b_q};
   // 64-bit signed division keeps 0x80000000 / -1 well defined.
   assign quo_s  = 32'(a_sx / b_sx);
   assign rem_s  = 32'(a_sx % b_sx);
   assign quo_u  = a_q / b_q;
   assign rem_u  = a_q % b_q;

   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;

      case (state_q)
         IDLE: begin
            if (md.start && !cancel_act) begin
               case (md.op)
                  OP_MULT, OP_MULTU: begin
                     state_d = MUL;
                     cnt_d   = MUL_CNT;
                     op_d    = op_e'(md.op);
                     a_d     = md.a;
                     b_d     = md.b;
                  end
                  OP_DIV, OP_DIVU: begin
                     state_d = DIV;
                     cnt_d   = DIV_CNT;
                     op_d    = op_e'(md.op);
                     a_d     = md.a;
                     b_d     = md.b;
                  end
                  OP_MTHI: hi_d = md.a;
                  OP_MTLO: lo_d = md.a;
                  default: ;
               endcase
            end
         end

         MUL, DIV: begin
            if (cancel_act) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d = IDLE;
               case (op_q)
                  OP_MULT:  {hi_d, lo_d} = prod_s;
                  OP_MULTU: {hi_d, lo_d} = prod_u;
                  // Divide by zero leaves HI/LO untouched but still costs the full latency.
                  OP_DIV: begin
                     if (b_q != '0) begin
                        lo_d = quo_s;
                        hi_d = rem_s;
                     end
                  end
                  OP_DIVU: begin
                     if (b_q != '0) begin
                        lo_d = quo_u;
                        hi_d = rem_u;
                     end
                  end
                  default: ;
               endcase
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= OP_NOP;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign md.busy  = (state_q != IDLE);
   assign md.stall = md.busy & (md.start | md.mf_req);
   assign md.hi    = hi_q;
   assign md.lo    = lo_q;

endmodule

// File: tb/tb_md_scheduler.sv
// Randomized scoreboard bench for md_scheduler: a driver predicts each op's result and
// commit cycle from plain arithmetic; an independent monitor checks HI/LO when it lands.
module tb_md_scheduler;

   localparam int MUL_LAT = 5;
   localparam int DIV_LAT = 10;

   typedef struct {
      int          due;
      logic [31:0] hi;
      logic [31:0] lo;
      int          len;
   } exp_t;

   logic clk;
   logic reset;
   md_scheduler_if md ();

   md_scheduler #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .md    (md)
   );

   int          n_cmp;
   int          n_bad;
   int          cyc;
   int          free_cyc;
   logic [31:0] mdl_hi, mdl_lo;
   logic [31:0] pre_hi, pre_lo;
   exp_t        sb_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, act=running exp=finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
      end
   endtask

   // Reference result of one op against the current architectural HI/LO.
   task automatic predict(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                          output logic [31:0] nh, output logic [31:0] nl, output int len);
      longint          sa, sb, qa, q, r, p;
      longint unsigned ua, ub, pu;
      nh  = mdl_hi;
      nl  = mdl_lo;
      len = 0;
      sa  = longint'(signed'(av));
      sb  = longint'(signed'(bv));
      ua  = longint'(av);
      ub  = longint'(bv);
      case (o)
         3'd1: begin p = sa * sb; nh = p[63:32]; nl = p[31:0]; len = MUL_LAT; end
         3'd2: begin pu = ua * ub; nh = pu[63:32]; nl = pu[31:0]; len = MUL_LAT; end
         3'd3: begin
            len = DIV_LAT;
            if (bv != 0) begin
               qa = (sa < 0 ? -sa : sa) / (sb < 0 ? -sb : sb);
               q  = ((sa < 0) != (sb < 0)) ? -qa : qa;
               r  = sa - q * sb;
               nl = 32'(q);
               nh = 32'(r);
            end
         end
         3'd4: begin
            len = DIV_LAT;
            if (bv != 0) begin nl = 32'(ua / ub); nh = 32'(ua % ub); end
         end
         3'd5: nh = av;
         3'd6: nl = av;
         default: ;
      endcase
   endtask

   // Present an op and hold it until the unit is free; returns just after the accepting edge.
   task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
      bit          done;
      int          budget;
      int          k;
      logic        exp_busy;
      logic [31:0] nh, nl;
      int          len;
      exp_t        it;
      done   = 0;
      budget = 0;
      while (!done) begin
         @(negedge clk);
         md.start  = 1'b1;
         md.op     = o;
         md.a      = av;
         md.b      = bv;
         md.mf_req = 1'b0;
         #1;
         exp_busy = (cyc < free_cyc);
         check("stall_on_start", {31'd0, md.stall}, {31'd0, exp_busy});
         check("busy_on_start", {31'd0, md.busy}, {31'd0, exp_busy});
         if (!exp_busy) begin
            k = cyc + 1;
            predict(o, av, bv, nh, nl, len);
            pre_hi = mdl_hi;
            pre_lo = mdl_lo;
            it.due = k + len;
            it.hi  = nh;
            it.lo  = nl;
            it.len = len;
            sb_q.push_back(it);
            mdl_hi   = nh;
            mdl_lo   = nl;
            free_cyc = k + len;
            done     = 1;
         end else if (++budget > 4 * DIV_LAT) begin
            check("accept_timeout", 32'd1, 32'd0);
            done = 1;
         end
      end
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         md.start  = 1'b0;
         md.mf_req = 1'b0;
         #1;
         check("stall_quiet", {31'd0, md.stall}, 32'd0);
      end
   endtask

   // mf_req with no start: stall follows busy and HI/LO keep their pre-op values.
   task automatic mf_hold(input int n);
      logic exp_busy;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         md.start  = 1'b0;
         md.mf_req = 1'b1;
         #1;
         exp_busy = (cyc < free_cyc);
         check("stall_mf_req", {31'd0, md.stall}, {31'd0, exp_busy});
         if (exp_busy) begin
            check("hi_no_bypass", md.hi, pre_hi);
            check("lo_no_bypass", md.lo, pre_lo);
         end
      end
      @(negedge clk);
      md.mf_req = 1'b0;
   endtask

   // Monitor: measures busy run length and checks each expected commit when it falls due.
   initial begin : monitor
      int   run;
      int   last_run;
      exp_t it;
      run      = 0;
      last_run = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            run = 0;
         end else begin
            if (md.busy) run++;
            else begin
               if (run > 0) last_run = run;
               run = 0;
            end
            while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
               it = sb_q.pop_front();
               check("hi_commit", md.hi, it.hi);
               check("lo_commit", md.lo, it.lo);
               check("busy_after_commit", {31'd0, md.busy}, 32'd0);
               if (it.len > 0) check("busy_length", 32'(last_run), 32'(it.len));
            end
         end
      end
   end

   initial begin : driver
      logic [2:0]  o;
      logic [31:0] av, bv;
      n_cmp     = 0;
      n_bad     = 0;
      free_cyc  = 0;
      mdl_hi    = '0;
      mdl_lo    = '0;
      pre_hi    = '0;
      pre_lo    = '0;
      reset     = 1'b1;
      md.start  = 1'b0;
      md.op     = '0;
      md.a      = '0;
      md.b      = '0;
      md.mf_req = 1'b0;
      md.cancel = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_busy", {31'd0, md.busy}, 32'd0);
      check("reset_stall", {31'd0, md.stall}, 32'd0);
      check("reset_hi", md.hi, 32'd0);
      check("reset_lo", md.lo, 32'd0);
      reset = 1'b0;

      // Directed cases from the datasheet examples.
      issue(3'd1, 32'hFFFF_FFFE, 32'd3);
      idle(MUL_LAT + 1);
      issue(3'd2, 32'hFFFF_FFFF, 32'd2);
      idle(MUL_LAT + 1);
      issue(3'd3, 32'hFFFF_FFF9, 32'd2);
      idle(DIV_LAT + 1);
      issue(3'd4, 32'd7, 32'd0);
      idle(DIV_LAT + 1);
      issue(3'd6, 32'h0000_1234, 32'd0);
      issue(3'd4, 32'd1000, 32'd7);
      mf_hold(DIV_LAT + 2);
      issue(3'd1, 32'd123, 32'd456);
      issue(3'd1, 32'h8000_0000, 32'hFFFF_FFFF);
      idle(2 * MUL_LAT + 2);
      issue(3'd0, 32'hDEAD_BEEF, 32'd1);
      issue(3'd7, 32'hDEAD_BEEF, 32'd1);
      issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      idle(DIV_LAT + 1);

      // Cancel raised in the last busy cycle (cnt==0).
      issue(3'd2, 32'd77, 32'd99);
      repeat (MUL_LAT - 1) begin
         @(negedge clk);
         md.start = 1'b0;
      end
      @(negedge clk);
      md.cancel = 1'b1;
`ifdef MD_CANCEL_EN
      begin
         exp_t it;
         it    = sb_q.pop_back();
         it.hi = pre_hi;
         it.lo = pre_lo;
         sb_q.push_back(it);
         mdl_hi = pre_hi;
         mdl_lo = pre_lo;
      end
`endif
      @(negedge clk);
      md.cancel = 1'b0;
      idle(2);

      // Asynchronous reset in the third busy cycle of a divide.
      issue(3'd5, 32'hAAAA_5555, 32'd0);
      issue(3'd3, 32'd100, 32'd3);
      repeat (3) @(negedge clk);
      md.start = 1'b0;
      reset    = 1'b1;
      #1;
      check("reset_mid_busy", {31'd0, md.busy}, 32'd0);
      check("reset_mid_hi", md.hi, 32'd0);
      check("reset_mid_lo", md.lo, 32'd0);
      sb_q.delete();
      mdl_hi   = '0;
      mdl_lo   = '0;
      free_cyc = 0;
      @(negedge clk);
      reset = 1'b0;
      idle(2);

      // Randomized traffic with back-to-back issue, mf_req holds and idle gaps.
      for (int i = 0; i < 40; i++) begin
         o  = 3'($urandom_range(0, 7));
         av = $urandom;
         bv = $urandom;
         case ($urandom_range(0, 3))
            0: bv = 32'($urandom_range(0, 3));
            1: av = 32'($urandom_range(0, 100));
            default: ;
         endcase
         issue(o, av, bv);
         case ($urandom_range(0, 2))
            0: mf_hold(int'($urandom_range(1, 4)));
            1: idle(1);
            default: ;
         endcase
      end
      idle(DIV_LAT + 3);
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
